// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the LC-3 memory access arbiter.
package mem_arb_pkg;

  localparam int DEF_AW      = 16;
  localparam int DEF_DW      = 16;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin pick between the fetch and data requesters.
// On a tie the requester that was not served last wins.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic    if_req,
  input  logic    d_req,
  input  req_id_e last_gnt,
  output logic    gnt_valid,
  output req_id_e gnt_id
);

  // Grant decode: single request wins outright, a tie alternates on last_gnt
  always_comb begin
    gnt_valid = if_req | d_req;
    gnt_id    = REQ_FETCH;
    if (if_req && d_req) begin
      gnt_id = (last_gnt == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (d_req) begin
      gnt_id = REQ_DATA;
    end else begin
      gnt_id = REQ_FETCH;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port memory sequencer/arbiter for the LC-3 fetch and load/store paths.
// Latches address and write data (MAR/MDR), holds the enables until mem_ready,
// then returns read data with a one-cycle done pulse to the granted requester.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES cycles in ACCESS; the aborted access completes with err=1, rdata=0.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  arb_state_e    state_r;
  req_id_e       gnt_id_r;
  req_id_e       last_gnt_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic [DW-1:0] rdata_r;
  logic          mem_re_r;
  logic          mem_we_r;
  logic          if_done_r;
  logic          d_done_r;
  logic          busy_r;
  logic          pick_valid_s;
  req_id_e       pick_id_s;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_r;
  logic          err_r;
`endif

  mem_arb_rr_pick u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .last_gnt  (last_gnt_r),
    .gnt_valid (pick_valid_s),
    .gnt_id    (pick_id_s)
  );

  // Access sequencer: IDLE -> ACCESS -> RESP, all outputs registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_id_r    <= REQ_FETCH;
      last_gnt_r  <= REQ_FETCH;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      rdata_r     <= {DW{1'b0}};
      mem_re_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      if_done_r   <= 1'b0;
      d_done_r    <= 1'b0;
      busy_r      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_r       <= {CW{1'b0}};
      err_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            gnt_id_r <= pick_id_s;
            busy_r   <= 1'b1;
            state_r  <= ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_r    <= {CW{1'b0}};
`endif
            if (pick_id_s == REQ_DATA) begin
              mem_addr_r  <= d_addr;
              mem_wdata_r <= d_wdata;
              mem_re_r    <= ~d_we;
              mem_we_r    <= d_we;
            end else begin
              // Fetches are always reads with cleared write data
              mem_addr_r  <= if_addr;
              mem_wdata_r <= {DW{1'b0}};
              mem_re_r    <= 1'b1;
              mem_we_r    <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            if (!mem_we_r) begin
              rdata_r <= mem_rdata;
            end else begin
              rdata_r <= rdata_r;
            end
            mem_re_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            if_done_r <= (gnt_id_r == REQ_FETCH);
            d_done_r  <= (gnt_id_r == REQ_DATA);
            state_r   <= RESP;
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (cnt_r == CNT_LAST) begin
            rdata_r   <= {DW{1'b0}};
            err_r     <= 1'b1;
            mem_re_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            if_done_r <= (gnt_id_r == REQ_FETCH);
            d_done_r  <= (gnt_id_r == REQ_DATA);
            state_r   <= RESP;
          end else begin
            cnt_r <= cnt_r + 1'b1;
`else
          end else begin
            state_r <= ACCESS;
`endif
          end
        end

        RESP: begin
          if_done_r  <= 1'b0;
          d_done_r   <= 1'b0;
          busy_r     <= 1'b0;
          last_gnt_r <= gnt_id_r;
          state_r    <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
          err_r      <= 1'b0;
`endif
        end

        default: begin
          mem_re_r  <= 1'b0;
          mem_we_r  <= 1'b0;
          if_done_r <= 1'b0;
          d_done_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign if_done   = if_done_r;
  assign d_done    = d_done_r;
  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_re    = mem_re_r;
  assign mem_we    = mem_we_r;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err       = err_r;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed, scoreboard-based bench for mem_access_arbiter.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] rdata;
  logic        err;
  logic        busy;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  typedef struct {
    logic        is_data;
    logic [15:0] addr;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   pass_cnt = 0;

  mem_access_arbiter #(.AW(16), .DW(16), .TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  // Scoreboard: every done pulse pops one expected completion
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (if_done === 1'b1 || d_done === 1'b1)) begin
      check("one_done_at_a_time", {31'd0, if_done & d_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_requester", {31'd0, d_done}, {31'd0, e.is_data});
        check("done_addr", {16'd0, mem_addr}, {16'd0, e.addr});
        check("done_rdata", {16'd0, rdata}, {16'd0, e.rdata});
        check("done_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; if_req = 1'b0; if_addr = 16'h0000; d_req = 1'b0; d_we = 1'b0;
    d_addr = 16'h0000; d_wdata = 16'h0000; mem_rdata = 16'h0000; mem_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_re", {31'd0, mem_re}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_done", {30'd0, if_done, d_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    // Fetch only, memory ready immediately
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h3000; mem_ready = 1'b1; mem_rdata = 16'h1234;
    e = '{is_data: 1'b0, addr: 16'h3000, rdata: 16'h1234, err: 1'b0}; exp_q.push_back(e);
    @(negedge clk);
    check("f_access_re", {31'd0, mem_re}, 32'd1);
    check("f_access_we", {31'd0, mem_we}, 32'd0);
    check("f_access_addr", {16'd0, mem_addr}, 32'h3000);
    check("f_access_busy", {31'd0, busy}, 32'd1);
    check("f_no_early_done", {31'd0, if_done}, 32'd0);
    @(negedge clk);
    check("f_done", {31'd0, if_done}, 32'd1);
    check("f_re_dropped", {31'd0, mem_re}, 32'd0);
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("f_idle_busy", {31'd0, busy}, 32'd0);
    check("f_done_one_cycle", {31'd0, if_done}, 32'd0);

    // Store with four wait cycles; rdata must keep the fetched value
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h4000; d_wdata = 16'hBEEF;
    e = '{is_data: 1'b1, addr: 16'h4000, rdata: 16'h1234, err: 1'b0}; exp_q.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s_we_held", {31'd0, mem_we}, 32'd1);
      check("s_re_low", {31'd0, mem_re}, 32'd0);
      check("s_addr_stable", {16'd0, mem_addr}, 32'h4000);
      check("s_wdata_stable", {16'd0, mem_wdata}, 32'hBEEF);
      check("s_no_done", {31'd0, d_done}, 32'd0);
      if (i == 4) begin
        mem_ready = 1'b1; mem_rdata = 16'hDEAD;
      end
    end
    @(negedge clk);
    check("s_done", {31'd0, d_done}, 32'd1);
    check("s_we_dropped", {31'd0, mem_we}, 32'd0);
    d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("s_idle_busy", {31'd0, busy}, 32'd0);

    // Both requests held from reset: data, fetch, data, fetch, every 3 cycles
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 16'h3100; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h5000;
    mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    for (int k = 0; k < 4; k++) begin
      e = '{is_data: (k % 2 == 0), addr: (k % 2 == 0) ? 16'h5000 : 16'h3100,
            rdata: 16'h5A5A, err: 1'b0};
      exp_q.push_back(e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      check("rr_done_cadence", {31'd0, if_done | d_done}, {31'd0, (i % 3 == 2)});
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("rr_scoreboard_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    check("rr_idle_busy", {31'd0, busy}, 32'd0);

    // Reset asserted in the middle of ACCESS
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h7000;
    @(negedge clk);
    check("r_access_re", {31'd0, mem_re}, 32'd1);
    check("r_access_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    check("r_re_dropped", {31'd0, mem_re}, 32'd0);
    check("r_busy_dropped", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r_no_done", {30'd0, if_done, d_done}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("r_idle_after_release", {31'd0, busy}, 32'd0);

    // Load after reset leaves a known nonzero rdata
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h6000; mem_ready = 1'b1; mem_rdata = 16'hCAFE;
    e = '{is_data: 1'b1, addr: 16'h6000, rdata: 16'hCAFE, err: 1'b0}; exp_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    check("l_done", {31'd0, d_done}, 32'd1);
    d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

    // Memory never ready
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h6100; mem_rdata = 16'hFFFF;
`ifdef MEM_ARB_TIMEOUT_EN
    e = '{is_data: 1'b1, addr: 16'h6100, rdata: 16'h0000, err: 1'b1}; exp_q.push_back(e);
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t_waiting_busy", {31'd0, busy}, 32'd1);
      check("t_waiting_re", {31'd0, mem_re}, 32'd1);
      check("t_waiting_no_done", {31'd0, d_done}, 32'd0);
    end
`ifdef MEM_ARB_TIMEOUT_EN
    @(negedge clk);
    check("t_abort_done", {31'd0, d_done}, 32'd1);
    check("t_abort_err", {31'd0, err}, 32'd1);
    check("t_abort_rdata", {16'd0, rdata}, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    check("t_idle_busy", {31'd0, busy}, 32'd0);
`else
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t_stuck_busy", {31'd0, busy}, 32'd1);
      check("t_stuck_no_done", {31'd0, d_done}, 32'd0);
      check("t_stuck_rdata", {16'd0, rdata}, 32'hCAFE);
    end
    rst_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t_recovered_idle", {31'd0, busy}, 32'd0);
`endif

    check("final_scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule
